// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: PC width, default
// return-address-stack depth and the next-PC source encoding used for trace.
package fetch_redirect_ctrl_pkg;

  localparam int PC_W          = 32;
  localparam int RAS_DEPTH_DEF = 8;

  // Where the next fetch address comes from this cycle.
  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,  // PC+4, no redirect
    NPC_ID_JAL = 3'd1,  // jal target predicted in ID
    NPC_ID_RAS = 3'd2,  // return address popped for jr $ra in ID
    NPC_ID_BR  = 3'd3,  // backward branch predicted taken in ID
    NPC_EX_FIX = 3'd4   // misprediction correction from EX
  } npc_src_e;

endpackage : fetch_redirect_ctrl_pkg

// File: rtl/fetch_redirect_ctrl_chk.sv
// Simulation checker for the fetch redirect controller's input contract.
module fetch_redirect_ctrl_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_id_valid,
  input logic i_id_is_jal,
  input logic i_id_is_jr_ra
);

  // A decoded instruction can never be both jal and jr $ra.
  a_jal_jr_exclusive : assert property (
    @(posedge i_clk) disable iff (i_rst)
      !(i_id_valid && i_id_is_jal && i_id_is_jr_ra)
  );

endmodule : fetch_redirect_ctrl_chk

// File: rtl/fetch_redirect_ctrl_ras_stack.sv
// Circular return address stack. Pushing onto a full stack overwrites the
// oldest entry, so the most recent RAS_DEPTH return addresses always survive.
module ras_stack
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = PC_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;      // next slot to write; top entry sits just below
  logic [PTR_W:0]   r_cnt;      // live entries, saturates at DEPTH
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == C_FULL);

  // Storage, pointer and occupancy update; push has priority over pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_cnt != C_FULL) begin
        r_cnt <= r_cnt + (PTR_W + 1)'(1);
      end
    end else if (i_pop && (r_cnt != '0)) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PTR_W + 1)'(1);
    end
  end

endmodule : ras_stack

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect controller: picks the next fetch source (sequential,
// ID prediction or EX correction), raises the pipeline flushes, drives the
// return address stack and counts EX corrections.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              stall,
  input  logic              id_valid,
  input  logic              id_is_jal,
  input  logic              id_is_jr_ra,
  input  logic              id_is_branch,
  input  logic              id_branch_backward,
  input  logic [PC_W-1:0]   id_pc_plus4,
  input  logic [PC_W-1:0]   id_branch_target,
  input  logic [PC_W-1:0]   id_jump_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_is_jr,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic              ex_actual_taken,
  input  logic [PC_W-1:0]   ex_actual_target,
  input  logic [PC_W-1:0]   ex_pc_plus4,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              id_pred_taken,
  output logic [PC_W-1:0]   id_pred_target,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              ras_empty,
  output logic              ras_full,
  output logic [CNT_W-1:0]  mispredict_count
);

  logic             w_ex_br_mp;
  logic             w_ex_jr_mp;
  logic             w_ex_mp;
  logic [PC_W-1:0]  w_ex_fix_pc;
  logic             w_id_en;
  npc_src_e         w_npc_src;
  logic             w_push;
  logic             w_pop;
  logic             w_pred_taken;
  logic [PC_W-1:0]  w_pred_target;
  logic [PC_W-1:0]  w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic [CNT_W-1:0] r_mp_cnt;

  // EX misprediction detection and the address that repairs it.
  always_comb begin
    w_ex_br_mp = ex_valid && ex_is_branch && (ex_pred_taken != ex_actual_taken);
    w_ex_jr_mp = ex_valid && ex_is_jr &&
                 (!ex_pred_taken || (ex_pred_target != ex_actual_target));
    w_ex_mp    = w_ex_br_mp || w_ex_jr_mp;
    if (ex_is_jr) begin
      w_ex_fix_pc = ex_actual_target;
    end else if (ex_actual_taken) begin
      w_ex_fix_pc = ex_actual_target;
    end else begin
      w_ex_fix_pc = ex_pc_plus4;
    end
  end

  // ID is wrong-path under an EX correction and frozen under a stall.
  assign w_id_en = id_valid && !stall && !w_ex_mp;

  // Next-PC source selection and ID static prediction, EX first.
  always_comb begin
    w_npc_src     = NPC_SEQ;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_pred_taken  = 1'b0;
    w_pred_target = '0;
    if (w_ex_mp) begin
      w_npc_src = NPC_EX_FIX;
    end else if (w_id_en) begin
      if (id_is_jal) begin
        w_npc_src     = NPC_ID_JAL;
        w_push        = 1'b1;
        w_pred_taken  = 1'b1;
        w_pred_target = id_jump_target;
      end else if (id_is_jr_ra && !w_ras_empty) begin
        w_npc_src     = NPC_ID_RAS;
        w_pop         = 1'b1;
        w_pred_taken  = 1'b1;
        w_pred_target = w_ras_top;
      end else if (id_is_branch && id_branch_backward) begin
        w_npc_src     = NPC_ID_BR;
        w_pred_taken  = 1'b1;
        w_pred_target = id_branch_target;
      end else begin
        w_npc_src = NPC_SEQ;
      end
    end else begin
      w_npc_src = NPC_SEQ;
    end
  end

  // Fetch redirect and flush generation from the selected source.
  always_comb begin
    redirect       = (w_npc_src != NPC_SEQ);
    flush_ifid     = (w_npc_src != NPC_SEQ);
    flush_idex     = (w_npc_src == NPC_EX_FIX);
    id_pred_taken  = w_pred_taken;
    id_pred_target = w_pred_target;
    case (w_npc_src)
      NPC_EX_FIX: redirect_pc = w_ex_fix_pc;
      NPC_ID_JAL: redirect_pc = w_pred_target;
      NPC_ID_RAS: redirect_pc = w_pred_target;
      NPC_ID_BR:  redirect_pc = w_pred_target;
      default:    redirect_pc = '0;
    endcase
  end

  // Saturating count of EX corrections.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_mp_cnt <= '0;
    end else if (w_ex_mp && (r_mp_cnt != '1)) begin
      r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  assign mispredict_count = r_mp_cnt;
  assign ras_empty        = w_ras_empty;
  assign ras_full         = w_ras_full;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .i_clk       (CLK),
    .i_rst       (Reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (id_pc_plus4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full)
  );

  fetch_redirect_ctrl_chk u_chk (
    .i_clk         (CLK),
    .i_rst         (Reset),
    .i_id_valid    (id_valid),
    .i_id_is_jal   (id_is_jal),
    .i_id_is_jr_ra (id_is_jr_ra)
  );

endmodule : fetch_redirect_ctrl

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fetch_redirect_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic        CLK = 1'b0;
  logic        Reset, stall, id_valid, id_is_jal, id_is_jr_ra, id_is_branch;
  logic        id_branch_backward, ex_valid, ex_is_branch, ex_is_jr;
  logic        ex_pred_taken, ex_actual_taken;
  logic [31:0] id_pc_plus4, id_branch_target, id_jump_target;
  logic [31:0] ex_pred_target, ex_actual_target, ex_pc_plus4;
  logic        redirect, id_pred_taken, flush_ifid, flush_idex, ras_empty, ras_full;
  logic [31:0] redirect_pc, id_pred_target;
  logic [CW-1:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_ras[$];
  int          m_cnt = 0;
  bit          m_push, m_pop, m_mp;

  always #5 CLK = ~CLK;

  fetch_redirect_ctrl #(.RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .stall(stall), .id_valid(id_valid),
    .id_is_jal(id_is_jal), .id_is_jr_ra(id_is_jr_ra), .id_is_branch(id_is_branch),
    .id_branch_backward(id_branch_backward), .id_pc_plus4(id_pc_plus4),
    .id_branch_target(id_branch_target), .id_jump_target(id_jump_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jr(ex_is_jr),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_actual_taken(ex_actual_taken), .ex_actual_target(ex_actual_target),
    .ex_pc_plus4(ex_pc_plus4), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .ras_empty(ras_empty),
    .ras_full(ras_full), .mispredict_count(mispredict_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    Reset = 1'b0; stall = 1'b0; id_valid = 1'b0; id_is_jal = 1'b0;
    id_is_jr_ra = 1'b0; id_is_branch = 1'b0; id_branch_backward = 1'b0;
    id_pc_plus4 = '0; id_branch_target = '0; id_jump_target = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jr = 1'b0; ex_pred_taken = 1'b0;
    ex_pred_target = '0; ex_actual_taken = 1'b0; ex_actual_target = '0;
    ex_pc_plus4 = '0;
  endtask

  // Compute expected outputs from the current inputs and model, compare all.
  task automatic settle();
    bit          mp, pt;
    logic [31:0] fix, tgt, exp_pc;
    #1;
    mp = (ex_valid && ex_is_branch && (ex_pred_taken != ex_actual_taken)) ||
         (ex_valid && ex_is_jr && (!ex_pred_taken || ex_pred_target != ex_actual_target));
    if (ex_is_jr) fix = ex_actual_target;
    else          fix = ex_actual_taken ? ex_actual_target : ex_pc_plus4;
    pt = 1'b0; tgt = '0; m_push = 1'b0; m_pop = 1'b0;
    if (id_valid && !stall && !mp) begin
      if (id_is_jal) begin
        pt = 1'b1; tgt = id_jump_target; m_push = 1'b1;
      end else if (id_is_jr_ra && m_ras.size() > 0) begin
        pt = 1'b1; tgt = m_ras[$]; m_pop = 1'b1;
      end else if (id_is_branch && id_branch_backward) begin
        pt = 1'b1; tgt = id_branch_target;
      end
    end
    m_mp = mp;
    exp_pc = mp ? fix : tgt;
    check_eq("redirect",    {31'd0, redirect},     {31'd0, mp | pt});
    check_eq("redirect_pc", redirect_pc,           exp_pc);
    check_eq("flush_ifid",  {31'd0, flush_ifid},   {31'd0, mp | pt});
    check_eq("flush_idex",  {31'd0, flush_idex},   {31'd0, mp});
    check_eq("ras_empty",   {31'd0, ras_empty},    {31'd0, m_ras.size() == 0});
    check_eq("ras_full",    {31'd0, ras_full},     {31'd0, m_ras.size() == DEPTH});
    check_eq("mp_count",    {16'd0, mispredict_count}, m_cnt);
    if (id_valid && !stall && !mp) begin
      check_eq("id_pred_taken",  {31'd0, id_pred_taken}, {31'd0, pt});
      check_eq("id_pred_target", id_pred_target,         tgt);
    end
  endtask

  // Clock edge, then apply the same state changes to the model.
  task automatic advance();
    @(posedge CLK);
    if (Reset) begin
      m_ras.delete();
      m_cnt = 0;
    end else begin
      if (m_push) begin
        m_ras.push_back(id_pc_plus4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (m_pop) begin
        void'(m_ras.pop_back());
      end
      if (m_mp && m_cnt < 65535) m_cnt++;
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    m_push = 1'b0; m_pop = 1'b0; m_mp = 1'b0;
    advance();
    Reset = 1'b1;
    advance();
  endtask

  initial begin
    clear_inputs();
    @(negedge CLK);
    do_reset();

    // idle after reset
    settle();
    check_eq("rst_empty", {31'd0, ras_empty}, 32'd1);
    check_eq("rst_count", {16'd0, mispredict_count}, 32'd0);
    advance();

    // jal then jr $ra returns through the RAS
    id_valid = 1'b1; id_is_jal = 1'b1; id_pc_plus4 = 32'h104; id_jump_target = 32'h180;
    settle();
    check_eq("jal_pc", redirect_pc, 32'h180);
    advance();
    id_valid = 1'b1; id_is_jr_ra = 1'b1;
    settle();
    check_eq("ret_pc", redirect_pc, 32'h104);
    check_eq("ret_pred", id_pred_target, 32'h104);
    advance();
    settle();
    check_eq("ret_empty", {31'd0, ras_empty}, 32'd1);
    advance();

    // nine pushes overflow depth 8, then eight pops
    for (int i = 1; i <= 9; i++) begin
      id_valid = 1'b1; id_is_jal = 1'b1; id_pc_plus4 = 32'(4 * i); id_jump_target = 32'h400;
      settle();
      advance();
      if (i >= 8) begin
        settle();
        check_eq("ovf_full", {31'd0, ras_full}, 32'd1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      id_valid = 1'b1; id_is_jr_ra = 1'b1;
      settle();
      check_eq("pop_pc", redirect_pc, 32'(32'h24 - 4 * i));
      advance();
    end
    settle();
    check_eq("pop_empty", {31'd0, ras_empty}, 32'd1);
    advance();

    // EX branch correction beats an ID jal
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pred_taken = 1'b1; ex_pred_target = 32'h60;
    ex_actual_taken = 1'b0; ex_pc_plus4 = 32'h7C;
    id_valid = 1'b1; id_is_jal = 1'b1; id_pc_plus4 = 32'h90; id_jump_target = 32'h300;
    settle();
    check_eq("fix_pc", redirect_pc, 32'h7C);
    check_eq("fix_idex", {31'd0, flush_idex}, 32'd1);
    advance();
    settle();
    check_eq("fix_nopush", {31'd0, ras_empty}, 32'd1);
    check_eq("fix_count", {16'd0, mispredict_count}, 32'd1);
    advance();

    // jr $ra on empty RAS: no prediction, EX corrects
    id_valid = 1'b1; id_is_jr_ra = 1'b1;
    settle();
    check_eq("jr_empty_redir", {31'd0, redirect}, 32'd0);
    advance();
    ex_valid = 1'b1; ex_is_jr = 1'b1; ex_actual_target = 32'h19C;
    settle();
    check_eq("jr_fix_pc", redirect_pc, 32'h19C);
    advance();
    settle();
    check_eq("jr_fix_count", {16'd0, mispredict_count}, 32'd2);
    advance();

    // stall blocks ID action but not an EX correction
    stall = 1'b1; id_valid = 1'b1; id_is_jal = 1'b1; id_pc_plus4 = 32'h50; id_jump_target = 32'h500;
    settle();
    check_eq("stall_redir", {31'd0, redirect}, 32'd0);
    advance();
    settle();
    check_eq("stall_nopush", {31'd0, ras_empty}, 32'd1);
    advance();
    stall = 1'b1; id_valid = 1'b1; id_is_jal = 1'b1; id_pc_plus4 = 32'h50; id_jump_target = 32'h500;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_actual_taken = 1'b1; ex_actual_target = 32'h200;
    settle();
    check_eq("stall_fix_pc", redirect_pc, 32'h200);
    advance();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      stall              = ($urandom_range(0, 7) == 0);
      id_valid           = ($urandom_range(0, 4) != 0);
      id_is_jal          = ($urandom_range(0, 2) == 0);
      id_is_jr_ra        = !id_is_jal && ($urandom_range(0, 2) == 0);
      id_is_branch       = $urandom_range(0, 1);
      id_branch_backward = $urandom_range(0, 1);
      id_pc_plus4        = {$urandom_range(0, 16'hFFFF), 2'b00};
      id_branch_target   = {$urandom_range(0, 16'hFFFF), 2'b00};
      id_jump_target     = {$urandom_range(0, 16'hFFFF), 2'b00};
      ex_valid           = $urandom_range(0, 1);
      ex_is_branch       = ($urandom_range(0, 2) == 0);
      ex_is_jr           = !ex_is_branch && ($urandom_range(0, 3) == 0);
      ex_pred_taken      = $urandom_range(0, 1);
      ex_actual_taken    = ($urandom_range(0, 3) != 0) ? ex_pred_taken : !ex_pred_taken;
      ex_actual_target   = {$urandom_range(0, 16'hFFFF), 2'b00};
      ex_pred_target     = $urandom_range(0, 1) ? ex_actual_target : {$urandom_range(0, 16'hFFFF), 2'b00};
      ex_pc_plus4        = {$urandom_range(0, 16'hFFFF), 2'b00};
      settle();
      advance();
    end

    // mid-run reset clears RAS and counter
    do_reset();
    settle();
    check_eq("rst2_count", {16'd0, mispredict_count}, 32'd0);
    advance();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_redirect_ctrl
